// File: rtl/memif_pkg.sv
// Shared types and defaults for the SRAM access sequencer (mem_iface).
// The optional wait-state counter is controlled by the MEMIF_WAIT_EN macro.
package memif_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_READ  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_FETCH = 2'd2
  } cmd_t;

endpackage

// File: rtl/memif_if.sv
// Controller-side request/response bundle between the CPU control unit and mem_iface.
interface memif_if
  import memif_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  // Handshake: the controller holds a level request (mem_read/mem_write/ir_fetch
  // with addr/wdata) and freezes while busy=1; a request is taken only in IDLE,
  // done pulses for one cycle when the access completes, err pulses for one
  // cycle on an illegal request mix (write combined with read or fetch).
  logic              mem_read;
  logic              mem_write;
  logic              ir_fetch;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] instr;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output mem_read, mem_write, ir_fetch, addr, wdata,
    input  rdata, instr, busy, done, err
  );

  modport slave (
    input  mem_read, mem_write, ir_fetch, addr, wdata,
    output rdata, instr, busy, done, err
  );

endinterface

// File: rtl/memif_wait_cnt.sv
// 4-bit wait-state counter: loads on access start, counts down, flags zero.
// Only instantiated when MEMIF_WAIT_EN is defined.
module memif_wait_cnt
  import memif_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_iface.sv
// Sequences controller read/write/fetch requests onto a synchronous SRAM port.
// Define MEMIF_WAIT_EN to add WAIT_CYCLES extra wait states per access.
module mem_iface
  import memif_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = 2
)(
  input  logic              clk,
  input  logic              rst,
  memif_if.slave            bus,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_in;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] instr_q;

  logic req_any, illegal, legal;
  logic accept, capture, cnt_zero;
  logic busy_c, done_c, err_c, ce_c, we_c;

  // Fetch outranks a simultaneous read; write may not be combined with anything.
  assign req_any = bus.mem_read | bus.mem_write | bus.ir_fetch;
  assign illegal = bus.mem_write & (bus.mem_read | bus.ir_fetch);
  assign legal   = req_any & ~illegal;

  always_comb begin
    cmd_in = CMD_WRITE;
    if (bus.ir_fetch)      cmd_in = CMD_FETCH;
    else if (bus.mem_read) cmd_in = CMD_READ;
  end

`ifdef MEMIF_WAIT_EN
  localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(WAIT_CYCLES);

  memif_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (W_LOAD),
    .dec      (state_q == WAIT),
    .zero     (cnt_zero)
  );
`else
  // No wait states: every access completes after a single WAIT cycle.
  assign cnt_zero = ((WAIT_CYCLES * 0) == 0);
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    err_c   = 1'b0;
    ce_c    = 1'b0;
    we_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (illegal) begin
          err_c = 1'b1;
        end else if (legal) begin
          busy_c  = 1'b1;
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        busy_c = 1'b1;
        ce_c   = 1'b1;
        we_c   = (cmd_q == CMD_WRITE);
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= CMD_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q   <= cmd_in;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (capture && (cmd_q == CMD_READ))  rdata_q <= sram_rdata;
      if (capture && (cmd_q == CMD_FETCH)) instr_q <= sram_rdata;
    end
  end

  assign sram_ce    = ce_c;
  assign sram_we    = we_c;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

  assign bus.rdata = rdata_q;
  assign bus.instr = instr_q;
  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.err   = err_c;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_iface.sv
// Randomized scoreboard bench for mem_iface against a transaction-level model
// with a behavioural SRAM; honours MEMIF_WAIT_EN (W=2) or default build (W=0).
module tb_mem_iface;
  import memif_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
`ifdef MEMIF_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  memif_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  state_t        dbg_state;

  mem_iface #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .dbg_state  (dbg_state)
  );

  // Behavioural SRAM seen by the DUT.
  logic [DW-1:0] sram_mem [65536];
  assign sram_rdata = sram_mem[sram_addr];
  always @(posedge clk) if (sram_ce && sram_we) sram_mem[sram_addr] <= sram_wdata;

  // ---------------- reference model ----------------
  typedef struct {
    cmd_t          kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] exp_instr;
    int            n;
  } txn_t;

  txn_t          exp_q[$];
  logic [DW-1:0] ref_mem [65536];
  logic [DW-1:0] mdl_rdata = '0;
  logic [DW-1:0] mdl_instr = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of one accepted request, issued at cycle n.
  task automatic model_accept(input logic r, input logic f, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int n);
    txn_t t;
    t.kind  = f ? CMD_FETCH : (r ? CMD_READ : CMD_WRITE);
    t.addr  = a;
    t.wdata = d;
    t.n     = n;
    case (t.kind)
      CMD_READ:  mdl_rdata = ref_mem[a];
      CMD_FETCH: mdl_instr = ref_mem[a];
      default:   ref_mem[a] = d;
    endcase
    t.exp_rdata = mdl_rdata;
    t.exp_instr = mdl_instr;
    exp_q.push_back(t);
  endtask

  // ---------------- monitor / scoreboard ----------------
  txn_t mt;
  int   ph;
  logic exp_err_m;

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        exp_err_m = bus.mem_write & (bus.mem_read | bus.ir_fetch);
        check("idle_err",  bus.err,  exp_err_m);
        check("idle_busy", bus.busy,
              (bus.mem_read | bus.mem_write | bus.ir_fetch) & ~exp_err_m);
        check("idle_done", bus.done, 1'b0);
        check("idle_ce",   sram_ce,  1'b0);
        check("idle_we",   sram_we,  1'b0);
      end else begin
        mt = exp_q[0];
        ph = cyc - mt.n;
        if (ph == 0) begin
          check("accept_busy", bus.busy, 1'b1);
          check("accept_ce",   sram_ce,  1'b0);
          check("accept_err",  bus.err,  1'b0);
        end else if (ph <= 1 + W) begin
          check("wait_busy", bus.busy,  1'b1);
          check("wait_ce",   sram_ce,   1'b1);
          check("wait_we",   sram_we,   mt.kind == CMD_WRITE);
          check("wait_addr", sram_addr, mt.addr);
          if (mt.kind == CMD_WRITE) check("wait_wdata", sram_wdata, mt.wdata);
          check("wait_done", bus.done,  1'b0);
        end else if (ph == 2 + W) begin
          check("done_pulse", bus.done,  1'b1);
          check("done_busy",  bus.busy,  1'b0);
          check("done_ce",    sram_ce,   1'b0);
          check("done_we",    sram_we,   1'b0);
          check("done_err",   bus.err,   1'b0);
          check("done_rdata", bus.rdata, mt.exp_rdata);
          check("done_instr", bus.instr, mt.exp_instr);
          void'(exp_q.pop_front());
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL latency: no done by phase %0d (expected at %0d)", ph, 2 + W);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic r, input logic w, input logic f,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.mem_read  = r;
    bus.mem_write = w;
    bus.ir_fetch  = f;
    bus.addr      = a;
    bus.wdata     = d;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  // mode 0: clear inputs after acceptance, 1: scramble them, 2: hold the request
  task automatic issue(input logic r, input logic w, input logic f,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input int mode);
    next_cycle();
    drive(r, w, f, a, d);
    model_accept(r, f, a, d, cyc);
    for (int i = 1; i <= 2 + W; i++) begin
      next_cycle();
      if (mode == 0)
        drive(1'b0, 1'b0, 1'b0, '0, '0);
      else if (mode == 1)
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom), DW'($urandom));
    end
  endtask

  task automatic illegal_req(input logic with_fetch);
    next_cycle();
    drive(~with_fetch, 1'b1, with_fetch, AW'($urandom), DW'($urandom));
  endtask

  // Reset asserted in the last (W=0) or second (W>0) WAIT cycle of a read.
  task automatic abort_read(input logic [AW-1:0] a);
    int abort_ph;
    abort_ph = (W > 0) ? 2 : 1;
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, a, '0);
    model_accept(1'b1, 1'b0, a, '0, cyc);
    for (int i = 1; i <= abort_ph; i++) begin
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, '0, '0);
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    void'(exp_q.pop_front());
    mdl_rdata = '0;
    mdl_instr = '0;
    @(negedge clk);
    check("abort_rdata", bus.rdata, mdl_rdata);
    check("abort_instr", bus.instr, mdl_instr);
    check("abort_ce",    sram_ce,   1'b0);
    check("abort_done",  bus.done,  1'b0);
    check("abort_state", dbg_state, IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] v;
    int op;
    for (int i = 0; i < 65536; i++) begin
      v = DW'($urandom);
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    sram_mem[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
    sram_mem[16'h0030] = 16'hA5A5; ref_mem[16'h0030] = 16'hA5A5;

    drive(1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", bus.rdata, 16'h0000);
    check("rst_instr", bus.instr, 16'h0000);
    check("rst_busy",  bus.busy,  1'b0);
    check("rst_done",  bus.done,  1'b0);
    check("rst_err",   bus.err,   1'b0);
    check("rst_ce",    sram_ce,   1'b0);
    @(posedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;

    issue(1'b1, 1'b0, 1'b0, 16'h0010, '0, 0);          // read 0xBEEF
    issue(1'b0, 1'b1, 1'b0, 16'h0020, 16'h1234, 0);    // write
    issue(1'b1, 1'b0, 1'b1, 16'h0030, '0, 0);          // fetch wins over read
    illegal_req(1'b0);                                 // write + read
    illegal_req(1'b1);                                 // write + fetch
    idle(1);
    issue(1'b1, 1'b0, 1'b0, 16'h0020, '0, 1);          // read back the write, scrambled inputs
    issue(1'b1, 1'b0, 1'b0, 16'h0040, '0, 2);          // held through DONE
    issue(1'b1, 1'b0, 1'b0, 16'h0040, '0, 0);          // re-accepted in next IDLE
    idle(1);
    abort_read(16'h0050);
    idle(2);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: issue(1'b1, 1'b0, 1'b0, AW'($urandom_range(0, 63)), '0, $urandom_range(0, 1));
        1: issue(1'b0, 1'b1, 1'b0, AW'($urandom_range(0, 63)), DW'($urandom), $urandom_range(0, 1));
        2: issue(1'b0, 1'b0, 1'b1, AW'($urandom_range(0, 63)), '0, $urandom_range(0, 1));
        3: issue(1'b1, 1'b0, 1'b1, AW'($urandom_range(0, 63)), '0, $urandom_range(0, 2));
        4: illegal_req(1'($urandom_range(0, 1)));
        default: issue(1'b1, 1'b0, 1'b0, AW'($urandom), '0, 0);
      endcase
      idle($urandom_range(0, 2));
    end
    abort_read(AW'($urandom_range(0, 63)));
    idle(5);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d transactions never completed", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_iface.md
MEM_IFACE -- requirements
Module: mem_iface

Interface
REQ-001 Parameter DATA_W, 16, data word width.
REQ-002 Parameter ADDR_W, 16, address width.
REQ-003 Parameter WAIT_CYCLES, 2, extra SRAM wait cycles per access; used only when MEMIF_WAIT_EN is defined.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 mem_read  in  1  data-read request from the controller (level).
REQ-007 mem_write  in  1  data-write request from the controller (level).
REQ-008 ir_fetch  in  1  instruction-fetch request from the controller (level).
REQ-009 addr  in  ADDR_W  request address.
REQ-010 wdata  in  DATA_W  write data.
REQ-011 rdata  out  DATA_W  memory data register; holds the last read result.
REQ-012 instr  out  DATA_W  instruction register; holds the last fetch result.
REQ-013 busy  out  1  stall to the controller; the controller holds its state while busy=1.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 err  out  1  one-cycle pulse on an illegal request combination.
REQ-016 sram_ce, sram_we  out  1 each  SRAM chip enable and write enable.
REQ-017 sram_addr  out  ADDR_W; sram_wdata  out  DATA_W; sram_rdata  in  DATA_W.

Function
REQ-018 FSM states: IDLE, WAIT, DONE.
REQ-019 Legal request in IDLE: exactly one of mem_read/mem_write/ir_fetch high, or ir_fetch and mem_read both high (fetch wins).
REQ-020 IDLE with a legal request: latch addr, wdata and command kind; load wait counter with W; next state WAIT.
REQ-021 mem_write together with mem_read or ir_fetch in IDLE: err=1 for that cycle, no access, stay IDLE.
REQ-022 busy = (state==WAIT) OR (state==IDLE AND legal request), combinational.
REQ-023 WAIT: sram_ce=1, sram_addr and sram_wdata from latches, sram_we=1 only for writes; counter==0 -> capture and go to DONE, else decrement.
REQ-024 Capture: a read loads sram_rdata into rdata; a fetch loads it into instr; a write changes neither.
REQ-025 DONE: done=1, busy=0, sram_ce=sram_we=0; next state IDLE unconditionally; requests are not sampled in DONE.
REQ-026 Latency: request accepted at cycle N, done at cycle N+2+W; WAIT lasts W+1 cycles.
REQ-027 Request inputs changing during WAIT are ignored; latched values govern the access.
REQ-028 sram_ce=sram_we=0 in IDLE and DONE.

Reset
REQ-029 rst=1 at any edge: state IDLE, counter 0, rdata=0, instr=0, latches 0.
REQ-030 Reset during WAIT aborts the access: no capture, no done, sram_ce=sram_we=0 from the next cycle.
REQ-031 Outputs during/after reset: busy=0 (absent a request), done=0, err=0.

Configuration
REQ-032 Macro MEMIF_WAIT_EN defined: W = WAIT_CYCLES (0..15); the counter is instantiated.
REQ-033 Macro absent: W = 0 fixed; WAIT_CYCLES ignored; no counter logic; latency N+2.

Structure
REQ-034 Package memif_pkg: state enum (IDLE/WAIT/DONE), command enum (CMD_READ/CMD_WRITE/CMD_FETCH), DATA_W/ADDR_W defaults.
REQ-035 Sub-module memif_wait_cnt: 4-bit load/decrement counter with a zero flag; instantiated only under MEMIF_WAIT_EN.

Verification
REQ-036 Read, W=2: mem_read=1, addr=0x0010, sram_rdata=0xBEEF -> busy=1 for cycles N..N+3, done at N+4, rdata=0xBEEF, instr unchanged.
REQ-037 Write, W=0 (macro off): mem_write=1, addr=0x0020, wdata=0x1234 -> one WAIT cycle with sram_we=1, sram_addr=0x0020, sram_wdata=0x1234; done at N+2.
REQ-038 Fetch with mem_read also high: ir_fetch=1, sram_rdata=0xA5A5 -> instr=0xA5A5, rdata unchanged.
REQ-039 mem_write and mem_read both high in IDLE -> err=1 for one cycle, busy=0, sram_ce=0, state IDLE.
REQ-040 rst=1 in second WAIT cycle of a read (W=2) -> no done, rdata=0, sram_ce=0 on the next cycle.
REQ-041 Request held high through DONE -> not accepted in DONE; new access starts in the following IDLE cycle.
